// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, command-controller state encoding and baud/timeout arithmetic
// Contents:
//   HDR/CMD_WR/CMD_RD/ACK/NAK  protocol byte values
//   state_t                    command-controller FSM states
//   baud_cycles()              clock cycles per bit (shared with uart_rx/uart_tx)
//   timeout_cycles()           clock cycles in a given number of 10-bit byte times
package uart_pkg;

    localparam logic [7:0] HDR    = 8'hA5;
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_EXEC,
        ST_RDWAIT,
        ST_RESP,
        ST_RESP_WAIT
    } state_t;

    // 64-bit intermediates: clk_mhz * 1e6 * 10 * bytes overflows 32 bits at common settings
    function automatic int unsigned baud_cycles(input int unsigned clk_mhz, input int unsigned baud);
        longint unsigned num;
        num = 64'(clk_mhz) * 64'd1_000_000;
        return 32'(num / 64'(baud));
    endfunction

    function automatic int unsigned timeout_cycles(input int unsigned clk_mhz, input int unsigned baud,
                                                   input int unsigned nbytes);
        longint unsigned num;
        num = 64'(nbytes) * 64'd10 * 64'(clk_mhz) * 64'd1_000_000;
        return 32'(num / 64'(baud));
    endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// uart_timeout_cnt: loadable down-counter with clear, enable and expire flag
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_load        load i_load_val (highest priority)
//   i_load_val    value loaded on i_load
//   i_clr         force count to zero
//   i_en          count down by one per cycle, stopping at zero
//   o_expire      enabled and count is zero
module uart_timeout_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_clr,
    input  logic         i_en,
    output logic         o_expire
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_count <= '0;
        else if (i_load) r_count <= i_load_val;
        else if (i_clr) r_count <= '0;
        else if (i_en && r_count != '0) r_count <= r_count - 1'b1;
    end

    assign o_expire = i_en && (r_count == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles 5-byte command frames, executes register writes/reads and sends a one-byte response
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rx_data, rx_data_valid      received byte and its one-cycle strobe
//   reg_addr, reg_wdata         register bus address/write data (held between strobes)
//   reg_wr_en, reg_rd_en        one-cycle register bus strobes
//   reg_rdata                   read data, valid the cycle after reg_rd_en
//   tx_data, tx_start, tx_busy  response byte, one-cycle transmit request, transmitter busy
//   busy                        high whenever not IDLE
//   frame_err_cnt               saturating count of checksum errors and timeouts
module uart_cmd_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rdata,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy,
    output logic [7:0] frame_err_cnt
);

    localparam int unsigned TIMEOUT_CYCLES = timeout_cycles(CLK_FREQ, BAUD_RATE, TIMEOUT_BYTES);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT_CYCLES - 1);

    state_t     r_state, w_next;
    logic [7:0] r_cmd, r_faddr, r_fdata;
    logic [7:0] r_reg_addr, r_reg_wdata, r_tx_data, r_err;
    logic       r_good, r_chk_bad, r_seen_busy;
    logic       w_in_frame, w_accept, w_expire, w_timeout;
    logic       w_wr, w_rd, w_start, w_chk_ok, w_cmd_ok;

    assign w_in_frame = r_state inside {ST_CMD, ST_ADDR, ST_DATA, ST_CHK};
    assign w_accept   = rx_data_valid && (w_in_frame || (r_state == ST_IDLE && rx_data == HDR));
    // a byte arriving in the expiry cycle wins over the timeout
    assign w_timeout  = w_expire && !rx_data_valid;
    assign w_chk_ok   = rx_data == (r_cmd ^ r_faddr ^ r_fdata);
    assign w_cmd_ok   = (r_cmd == CMD_WR) || (r_cmd == CMD_RD);

    // Counts from TIMEOUT_CYCLES-1 down to zero; zero therefore marks the cycle
    // in which an up-count from the last accepted byte would reach TIMEOUT_CYCLES-1.
    uart_timeout_cnt #(.W(TW)) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_load_val (TLOAD),
        .i_clr      (!w_in_frame),
        .i_en       (w_in_frame),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_wr    = 1'b0;
        w_rd    = 1'b0;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE:      w_next = (rx_data_valid && rx_data == HDR) ? ST_CMD : ST_IDLE;
            ST_CMD:       w_next = rx_data_valid ? ST_ADDR : (w_timeout ? ST_IDLE : ST_CMD);
            ST_ADDR:      w_next = rx_data_valid ? ST_DATA : (w_timeout ? ST_IDLE : ST_ADDR);
            ST_DATA:      w_next = rx_data_valid ? ST_CHK : (w_timeout ? ST_IDLE : ST_DATA);
            ST_CHK:       w_next = rx_data_valid ? ST_EXEC : (w_timeout ? ST_IDLE : ST_CHK);
            ST_EXEC: begin
                w_wr   = r_good && (r_cmd == CMD_WR);
                w_rd   = r_good && (r_cmd == CMD_RD);
                w_next = w_rd ? ST_RDWAIT : ST_RESP;
            end
            ST_RDWAIT:    w_next = ST_RESP;
            ST_RESP: begin
                w_start = !tx_busy;
                w_next  = tx_busy ? ST_RESP : ST_RESP_WAIT;
            end
            ST_RESP_WAIT: w_next = (r_seen_busy && !tx_busy) ? ST_IDLE : ST_RESP_WAIT;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd       <= '0;
            r_faddr     <= '0;
            r_fdata     <= '0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_tx_data   <= '0;
            r_err       <= '0;
            r_good      <= 1'b0;
            r_chk_bad   <= 1'b0;
            r_seen_busy <= 1'b0;
        end else begin
            if (rx_data_valid && r_state == ST_CMD) r_cmd <= rx_data;
            if (rx_data_valid && r_state == ST_ADDR) r_faddr <= rx_data;
            if (rx_data_valid && r_state == ST_DATA) r_fdata <= rx_data;
            // bus address/data are published at the CHK byte so they are stable during the strobe
            if (rx_data_valid && r_state == ST_CHK) begin
                r_good    <= w_chk_ok && w_cmd_ok;
                r_chk_bad <= !w_chk_ok;
                if (w_chk_ok && w_cmd_ok) r_reg_addr <= r_faddr;
                if (w_chk_ok && r_cmd == CMD_WR) r_reg_wdata <= r_fdata;
            end
            if (r_state == ST_EXEC && !w_rd) r_tx_data <= w_wr ? ACK : NAK;
            if (r_state == ST_RDWAIT) r_tx_data <= reg_rdata;
            // the transmitter must be seen busy before its falling edge ends the response
            r_seen_busy <= (r_state == ST_RESP_WAIT) && (r_seen_busy || tx_busy);
            if ((r_state == ST_EXEC && r_chk_bad) || (w_in_frame && w_timeout))
                r_err <= (r_err == 8'hFF) ? r_err : r_err + 8'd1;
        end
    end

    assign reg_addr      = r_reg_addr;
    assign reg_wdata     = r_reg_wdata;
    assign reg_wr_en     = w_wr;
    assign reg_rd_en     = w_rd;
    assign tx_data       = r_tx_data;
    assign tx_start      = w_start;
    assign busy          = r_state != ST_IDLE;
    assign frame_err_cnt = r_err;

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command-frame controller between uart_rx and the UART transmitter. It assembles the received byte stream into fixed 5-byte command frames, checks them, and executes register writes or reads on a simple 8-bit register bus. It then schedules a one-byte response (ACK, read data or NAK) onto the transmitter through a start/busy handshake. It is the single master that configures on-chip registers over the serial link.

Parameters:
CLK_FREQ, 50, system clock in MHz
BAUD_RATE, 115200, link baud rate; used only for the timeout
TIMEOUT_BYTES, 4, inter-byte timeout in byte times; TIMEOUT_CYCLES = TIMEOUT_BYTES*10*CLK_FREQ*1_000_000/BAUD_RATE

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte from uart_rx
rx_data_valid  in  1  one-cycle strobe, rx_data valid
reg_addr  out  8  register address
reg_wdata  out  8  register write data
reg_wr_en  out  1  one-cycle write strobe
reg_rd_en  out  1  one-cycle read strobe
reg_rdata  in  8  read data, valid the cycle after reg_rd_en
tx_data  out  8  response byte
tx_start  out  1  one-cycle transmit request
tx_busy  in  1  transmitter busy; rises the cycle after tx_start, falls when the byte is done
busy  out  1  high in every state except IDLE
frame_err_cnt  out  8  saturating count of checksum errors and timeouts

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE; the timeout counter is 0.
  - Assertion mid-frame or mid-response aborts immediately. No strobe is issued after release.
- Frame format: 0xA5 header, CMD, ADDR, DATA, CHK, where CHK = CMD^ADDR^DATA. CMD 0x01 = write, 0x02 = read. DATA is ignored for reads but must still be sent.
- FSM states: IDLE, CMD, ADDR, DATA, CHK, EXEC, RDWAIT, RESP, RESP_WAIT.
  - IDLE: a byte equal to 0xA5 moves to CMD. Any other byte is discarded silently.
  - CMD/ADDR/DATA: each accepted byte is latched and the FSM advances. A byte equal to 0xA5 is treated as data, with no resync.
  - CHK: on the byte, the FSM goes to EXEC. It also computes good = (chk match) and (CMD is 0x01 or 0x02).
  - EXEC, one cycle:
    - good write: reg_wr_en=1 with reg_addr/reg_wdata, then RESP with tx_data=0x06.
    - good read: reg_rd_en=1, then RDWAIT.
    - bad: no bus strobe, tx_data=0x15, then RESP.
    - Checksum mismatch increments frame_err_cnt. A valid checksum with an unknown CMD gives NAK without incrementing.
  - RDWAIT, one cycle: tx_data <= reg_rdata, then RESP.
  - RESP: when tx_busy=0, pulse tx_start for one cycle and go to RESP_WAIT. Otherwise hold.
  - RESP_WAIT: wait for tx_busy to rise, then fall, then return to IDLE.
- Latency (V = cycle in which the CHK byte's rx_data_valid is high):
  - reg_wr_en or reg_rd_en is high in cycle V+1.
  - Write: tx_start at V+2 at the earliest.
  - Read: tx_start at V+3 at the earliest.
- Timeout:
  - The counter runs only in CMD..CHK and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE, frame_err_cnt increments, and no response is sent.
  - If a byte arrives in the same cycle as expiry, the byte wins and the counter clears.
- Bytes arriving in EXEC, RDWAIT, RESP or RESP_WAIT are dropped. They do not start a new frame.
- frame_err_cnt saturates at 255 and never wraps.
- reg_addr and reg_wdata hold their last values outside the strobes. tx_data holds until the next response.

Decomposition:
- Shared package uart_pkg holds:
  - constants HDR=8'hA5, CMD_WR=8'h01, CMD_RD=8'h02, ACK=8'h06, NAK=8'h15;
  - the FSM state enum;
  - the baud-cycle constant function shared with uart_rx/uart_tx.
- One sub-module, uart_timeout_cnt: a loadable down-counter with clear/enable/expire, reused by other serial controllers.

Test Plan:
- Write: send A5 01 10 3C 2D -> reg_wr_en pulses once with addr=0x10, wdata=0x3C; then one tx_start with tx_data=0x06; frame_err_cnt=0.
- Read: send A5 02 20 00 22 with reg_rdata=0x5A -> one reg_rd_en pulse with addr=0x20; tx_data=0x5A, tx_start once.
- Bad checksum: send A5 01 10 3C 00 -> no reg_wr_en; tx_data=0x15; frame_err_cnt=1. Unknown CMD (A5 07 00 00 07) -> NAK, counter unchanged.
- Timeout: send A5 01 then idle more than TIMEOUT_CYCLES -> returns to IDLE, frame_err_cnt +1, no tx_start. A following valid frame is executed normally.
- Noise and tx backpressure: stray 00 FF before the header are ignored. Hold tx_busy=1 across EXEC -> tx_start is delayed until tx_busy=0. Bytes sent during RESP_WAIT are dropped.
- Reset mid-frame after A5 01 10 -> all outputs 0, busy=0. A complete frame after reset executes exactly once.
